// File: rtl/vga_pkg.sv
// Purpose: shared region codes, 640x480@60 timing constants and axis helpers for the VGA timing generator.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package vga_pkg;

    // Region of one axis; order matches the scan order along the axis.
    typedef enum logic [1:0] {
        REG_ACTIVE = 2'd0,
        REG_FRONT  = 2'd1,
        REG_SYNC   = 2'd2,
        REG_BACK   = 2'd3
    } region_e;

    // Standard 640x480@60 Hz timing (25.175 MHz pixel clock).
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;
    localparam int VGA640_CW       = 10;

    // Length of one axis period in counter steps.
    function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Purpose: one scan axis: counter 0..TOTAL-1 with wrap flag and region decode.
// Latency: count updates one clock after advance; wrap and region are combinational from the count.
// Backpressure: none; advance is a pure enable, clear has priority over advance.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACT  = VGA640_H_ACTIVE,
    parameter int FP   = VGA640_H_FP,
    parameter int SYNC = VGA640_H_SYNC,
    parameter int BP   = VGA640_H_BP,
    parameter int CW   = VGA640_CW
) (
    input  logic          i_clk,
    input  logic          i_clear,
    input  logic          i_advance,
    output logic [CW-1:0] o_count,
    output logic          o_wrap,
    output region_e       o_region
);

    localparam int            TOTAL = axis_total(ACT, FP, SYNC, BP);
    localparam logic [CW-1:0] LAST  = CW'(TOTAL - 1);
    localparam logic [CW-1:0] A_END = CW'(ACT);
    localparam logic [CW-1:0] F_END = CW'(ACT + FP);
    localparam logic [CW-1:0] S_END = CW'(ACT + FP + SYNC);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          wrap;

    // Next count: step on advance, fold back to zero after the last position.
    always_comb begin
        wrap    = i_advance && (count_q == LAST);
        count_d = count_q;
        if (wrap) begin
            count_d = '0;
        end else if (i_advance) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register; clear (reset or idle) wins over everything.
    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Region decode from the registered count.
    always_comb begin
        if (count_q < A_END) begin
            o_region = REG_ACTIVE;
        end else if (count_q < F_END) begin
            o_region = REG_FRONT;
        end else if (count_q < S_END) begin
            o_region = REG_SYNC;
        end else begin
            o_region = REG_BACK;
        end
    end

    assign o_count = count_q;
    assign o_wrap  = wrap;

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose: VGA raster timing: pixel divider, h/v counters, syncs, data enable, strobes and color gate.
// Latency: timing outputs decode registered state; o_color is a zero-latency gate of i_color.
// Backpressure: none; i_enable low idles the raster and the next enabled cycle restarts at (0,0).
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA640_H_ACTIVE,
    parameter int H_FP     = VGA640_H_FP,
    parameter int H_SYNC   = VGA640_H_SYNC,
    parameter int H_BP     = VGA640_H_BP,
    parameter int V_ACTIVE = VGA640_V_ACTIVE,
    parameter int V_FP     = VGA640_V_FP,
    parameter int V_SYNC   = VGA640_V_SYNC,
    parameter int V_BP     = VGA640_V_BP,
    parameter int CLK_DIV  = 1,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = VGA640_CW,
    parameter int COLOR_W  = 12
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic [COLOR_W-1:0] i_color,
    output logic [COLOR_W-1:0] o_color,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_de,
    output logic [CW-1:0]      o_x,
    output logic [CW-1:0]      o_y,
    output logic               o_pix_stb,
    output logic               o_line_start,
    output logic               o_frame_start
);

    localparam int               H_TOTAL  = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int               V_TOTAL  = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam longint           CNT_MAX  = (longint'(1) << CW) - 1;

    // Reject geometries the counters cannot represent or that have an empty region.
    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
        CLK_DIV < 1 || CLK_DIV > 16 ||
        longint'(H_TOTAL - 1) > CNT_MAX || longint'(V_TOTAL - 1) > CNT_MAX) begin : g_bad_params
        $error("vga_timing_gen: zero timing parameter, CLK_DIV out of 1..16, or totals exceed CW");
    end

    // run_q low means idle: counters parked at zero, all outputs inactive.
    // The first enabled edge only sets run_q, so pixel (0,0) is shown for its full CLK_DIV cycles.
    logic             run_q;
    logic             run_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    logic             axis_clear;
    logic             h_adv;
    logic [CW-1:0]    h_count;
    logic [CW-1:0]    v_count;
    logic             h_wrap;
    logic             v_wrap_unused;
    region_e          h_region;
    region_e          v_region;

    // Next run flag and pixel divider.
    always_comb begin
        run_d = run_q;
        div_d = div_q;
        if (i_reset || !i_enable) begin
            run_d = 1'b0;
            div_d = '0;
        end else if (!run_q) begin
            run_d = 1'b1;
            div_d = '0;
        end else if (div_q == DIV_LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Run flag and divider registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            run_q <= 1'b0;
            div_q <= '0;
        end else begin
            run_q <= run_d;
            div_q <= div_d;
        end
    end

    assign axis_clear = i_reset || !i_enable;
    assign h_adv      = run_q && (div_q == DIV_LAST);

    vga_axis_counter #(
        .ACT  (H_ACTIVE),
        .FP   (H_FP),
        .SYNC (H_SYNC),
        .BP   (H_BP),
        .CW   (CW)
    ) u_h_axis (
        .i_clk     (i_clk),
        .i_clear   (axis_clear),
        .i_advance (h_adv),
        .o_count   (h_count),
        .o_wrap    (h_wrap),
        .o_region  (h_region)
    );

    // End of frame is already visible as frame_start, so the vertical wrap has no consumer.
    vga_axis_counter #(
        .ACT  (V_ACTIVE),
        .FP   (V_FP),
        .SYNC (V_SYNC),
        .BP   (V_BP),
        .CW   (CW)
    ) u_v_axis (
        .i_clk     (i_clk),
        .i_clear   (axis_clear),
        .i_advance (h_wrap),
        .o_count   (v_count),
        .o_wrap    (v_wrap_unused),
        .o_region  (v_region)
    );

    // Output decode from registered state only; the color gate is the sole input-to-output path.
    always_comb begin
        o_pix_stb     = run_q && (div_q == '0);
        o_line_start  = o_pix_stb && (h_count == '0);
        o_frame_start = o_line_start && (v_count == '0);
        o_de          = run_q && (h_region == REG_ACTIVE) && (v_region == REG_ACTIVE);
        o_hsync       = (run_q && h_region == REG_SYNC) ? HS_POL : ~HS_POL;
        o_vsync       = (run_q && v_region == REG_SYNC) ? VS_POL : ~VS_POL;
        o_x           = h_count;
        o_y           = v_count;
        o_color       = o_de ? i_color : '0;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have parameter CLK_DIV, default 1, i_clk cycles per pixel (1..16).
REQ-010 SHALL have parameter HS_POL, default 0, hsync level during sync (0 = active-low).
REQ-011 SHALL have parameter VS_POL, default 0, vsync level during sync.
REQ-012 SHALL have parameter CW, default 10, x/y counter width.
REQ-013 SHALL have parameter COLOR_W, default 12, color bus width.
REQ-014 SHALL have port i_clk, input, 1, sole clock; all logic on its rising edge.
REQ-015 SHALL have port i_reset, input, 1, synchronous active-high reset.
REQ-016 SHALL have port i_enable, input, 1, run when high; hold idle when low.
REQ-017 SHALL have port i_color, input, COLOR_W, pixel color for the current o_x/o_y.
REQ-018 SHALL have port o_color, output, COLOR_W, gated color to DAC.
REQ-019 SHALL have port o_hsync, output, 1, horizontal sync.
REQ-020 SHALL have port o_vsync, output, 1, vertical sync.
REQ-021 SHALL have port o_de, output, 1, high inside the visible area.
REQ-022 SHALL have ports o_x and o_y, output, CW each, raw horizontal/vertical counters.
REQ-023 SHALL have port o_pix_stb, output, 1, one-cycle strobe on the first i_clk of each pixel.
REQ-024 SHALL have port o_line_start, output, 1, one-cycle strobe on the first i_clk of pixel x=0, every line.
REQ-025 SHALL have port o_frame_start, output, 1, one-cycle strobe on the first i_clk of pixel (0,0).

Function
REQ-026 Divider SHALL count 0..CLK_DIV-1; pixel advances when divider = CLK_DIV-1; CLK_DIV=1 advances every cycle.
REQ-027 h counter SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H_* params) and wrap to 0; v counter SHALL increment only on the h wrap and wrap to 0 after V_TOTAL-1.
REQ-028 Each axis SHALL decode region ACTIVE [0,ACT), FRONT [ACT,ACT+FP), SYNC [ACT+FP,ACT+FP+SYNC), BACK [remainder].
REQ-029 o_hsync SHALL equal HS_POL while h is in SYNC, else ~HS_POL; o_vsync likewise on v with VS_POL, whole lines only.
REQ-030 o_de SHALL be high iff h < H_ACTIVE and v < V_ACTIVE; o_x = h, o_y = v always.
REQ-031 o_color SHALL equal i_color when o_de, else all zeros (combinational gate, zero latency).
REQ-032 All other outputs SHALL be decoded from registered counter state with no combinational path from inputs.
REQ-033 i_enable low SHALL, next cycle, force h=v=divider=0, o_de=0, syncs inactive, and all strobes low.
REQ-034 First cycle with i_enable high after idle or reset SHALL present (0,0) with o_pix_stb, o_line_start and o_frame_start all high.
REQ-035 An elaboration-time check SHALL fail if H_TOTAL-1 or V_TOTAL-1 exceeds 2^CW-1, or if any timing parameter is 0.

Reset
REQ-036 i_reset SHALL take priority over i_enable and, next cycle, set h=v=divider=0, o_de=0, o_hsync=~HS_POL, o_vsync=~VS_POL, all strobes 0.
REQ-037 Reset asserted mid-frame SHALL abort the frame with no partial sync pulse.

Structure
REQ-038 Region codes (ACTIVE=0, FRONT=1, SYNC=2, BACK=3) and standard 640x480@60 constants SHALL live in shared package vga_pkg.
REQ-039 Sub-module vga_axis_counter (inputs: clear, advance; outputs: count, wrap, region) SHALL be instantiated twice, once per axis.

Verification (small config: H 8/2/3/1, V 4/1/2/1, CLK_DIV=2 unless noted)
REQ-040 Reset high 3 cycles, enable=1, then release -> first cycle o_x=0, o_y=0, o_de=1, o_frame_start=1, o_hsync=1, o_vsync=1.
REQ-041 CLK_DIV=1, line period -> o_hsync=0 for exactly h=10..12 (3 cycles); o_line_start every 14 cycles.
REQ-042 Full frame -> o_frame_start every 224 cycles; o_vsync=0 for lines 5..6 (56 cycles); o_de=1 for 8x4 pixels x 2 cycles.
REQ-043 i_enable low at h=5,v=2 -> next cycle h=v=0, o_de=0, syncs=1; re-enable -> o_frame_start=1 on the first cycle.
REQ-044 i_color=12'hABC held -> o_color=12'hABC at h=7, 12'h000 at h=8 and at v=4.
REQ-045 HS_POL=1, VS_POL=1 -> o_hsync=1 only during h=10..12; o_vsync=1 only during lines 5..6.
